// File: rtl/motor_dose_scheduler.sv
// motor_dose_scheduler: runs the R, G and B dispensing motors one after another
// for their latched tick counts, with an all-off gap between executed colours.
// Optional pause/resume on start while running: define MOTOR_SCHED_PAUSE_EN.
module motor_dose_scheduler #(
    parameter int CNT_W     = 5,
    parameter int TICK_DIV  = 4,
    parameter int GAP_TICKS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             RGB_full,
    input  logic [CNT_W-1:0] R,
    input  logic [CNT_W-1:0] G,
    input  logic [CNT_W-1:0] B,
    output logic [2:0]       Motores,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] remaining
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [2:0][CNT_W-1:0]   cnt_q;
    logic [1:0]              ch_q;
    logic [PRE_W-1:0]        pre_q;
    logic [GAP_W-1:0]        gap_q;
    logic [CNT_W-1:0]        rem_q;
    logic [2:0]              motors_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    aborted_q;
    logic [1:0]              phase_q;

    logic                    tick;
    logic                    run_last;
    logic                    gap_last;
    logic                    ends_seq;
    logic                    active;
    logic [2:0]              first_sel;
    logic [2:0]              next_sel;
    logic                    paused_q;
    logic                    pause_req;
    logic                    resume_req;

    // Lowest channel index >= from with a nonzero count: {found, index}.
    function automatic logic [2:0] scan_from(input logic [1:0] from,
                                             input logic [2:0][CNT_W-1:0] cnt);
        logic [2:0] sel;
        sel = 3'b000;
        for (int i = 2; i >= 0; i--) begin
            if (i >= int'(from) && cnt[i] != '0) sel = {1'b1, 2'(i)};
        end
        return sel;
    endfunction

    // Tick, end-of-run/gap detection and next-channel lookahead.
    always_comb begin
        tick      = (pre_q == PRE_LAST);
        first_sel = scan_from(2'd0, cnt_q);
        next_sel  = scan_from(ch_q + 2'd1, cnt_q);
        run_last  = (state_q == S_RUN) && tick && (rem_q == CNT_W'(1));
        gap_last  = (state_q == S_GAP) && tick && (gap_q == GAP_W'(1));
        ends_seq  = run_last && !next_sel[2];
        active    = (state_q == S_RUN) || (state_q == S_GAP);
    end

`ifdef MOTOR_SCHED_PAUSE_EN
    // A pause requested on the final tick is dropped: the sequence is ending anyway.
    assign pause_req  = active && start && !abort && !paused_q && !ends_seq;
    assign resume_req = active && start && !abort && paused_q;

    // Pause flag toggles on start while running, cleared when the sequence ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            paused_q <= 1'b0;
        end else if (!active || abort) begin
            paused_q <= 1'b0;
        end else if (pause_req) begin
            paused_q <= 1'b1;
        end else if (resume_req) begin
            paused_q <= 1'b0;
        end
    end
`else
    assign paused_q   = 1'b0;
    assign pause_req  = 1'b0;
    assign resume_req = 1'b0;
`endif

    // Sequencer FSM with all outputs registered so Motores never glitches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ch_q      <= 2'd0;
            pre_q     <= '0;
            gap_q     <= '0;
            rem_q     <= '0;
            motors_q  <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            phase_q   <= 2'd3;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    motors_q <= 3'b000;
                    busy_q   <= 1'b0;
                    phase_q  <= 2'd3;
                    rem_q    <= '0;
                    pre_q    <= '0;
                    gap_q    <= '0;
                    if (start && RGB_full && !abort) begin
                        cnt_q   <= {B, G, R};
                        ch_q    <= 2'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q   <= S_IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                    end else if (first_sel[2]) begin
                        state_q  <= S_RUN;
                        ch_q     <= first_sel[1:0];
                        rem_q    <= cnt_q[first_sel[1:0]];
                        motors_q <= 3'b001 << first_sel[1:0];
                        phase_q  <= first_sel[1:0];
                        pre_q    <= '0;
                    end else begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_RUN, S_GAP: begin
                    if (abort) begin
                        state_q   <= S_IDLE;
                        motors_q  <= 3'b000;
                        rem_q     <= '0;
                        gap_q     <= '0;
                        busy_q    <= 1'b0;
                        phase_q   <= 2'd3;
                        aborted_q <= 1'b1;
                    end else if (paused_q) begin
                        // Everything frozen; only the motor drive comes back on resume.
                        if (resume_req && state_q == S_RUN) motors_q <= 3'b001 << ch_q;
                    end else begin
                        pre_q <= tick ? '0 : pre_q + PRE_W'(1);
                        if (state_q == S_RUN) begin
                            if (tick) rem_q <= rem_q - CNT_W'(1);
                            if (run_last) begin
                                if (!next_sel[2]) begin
                                    state_q  <= S_DONE;
                                    motors_q <= 3'b000;
                                    busy_q   <= 1'b0;
                                    done_q   <= 1'b1;
                                    phase_q  <= 2'd3;
                                end else if (GAP_TICKS > 0) begin
                                    state_q  <= S_GAP;
                                    ch_q     <= next_sel[1:0];
                                    gap_q    <= GAP_LOAD;
                                    motors_q <= 3'b000;
                                    phase_q  <= 2'd3;
                                end else begin
                                    ch_q     <= next_sel[1:0];
                                    rem_q    <= cnt_q[next_sel[1:0]];
                                    motors_q <= 3'b001 << next_sel[1:0];
                                    phase_q  <= next_sel[1:0];
                                end
                            end
                        end else begin
                            if (tick) gap_q <= gap_q - GAP_W'(1);
                            if (gap_last) begin
                                state_q  <= S_RUN;
                                rem_q    <= cnt_q[ch_q];
                                motors_q <= 3'b001 << ch_q;
                                phase_q  <= ch_q;
                            end
                        end
                        if (pause_req) motors_q <= 3'b000;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign Motores   = motors_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign phase     = phase_q;
    assign remaining = rem_q;

endmodule
